// File: rtl/cbfp_out_frame_buffer.sv
// Receive side of the CBFP output stream: wide valid-only frames land in a
// two-bank ping-pong store and are replayed as a narrow ready/valid stream.
module cbfp_out_frame_buffer #(
  parameter int DATA_W    = 13,
  parameter int LANES_IN  = 16,
  parameter int LANES_OUT = 4,
  parameter int FRAME_LEN = 512,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_re_in [0:LANES_IN-1],
  input  logic [DATA_W-1:0] data_im_in [0:LANES_IN-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re [0:LANES_OUT-1],
  output logic [DATA_W-1:0] out_im [0:LANES_OUT-1],
  output logic              out_sof,
  output logic              out_eof,
  output logic              overflow_err,
  output logic [CNT_W-1:0]  overflow_cnt
);

  localparam int WBEATS = FRAME_LEN / LANES_IN;
  localparam int RBEATS = FRAME_LEN / LANES_OUT;
  localparam int WB_W   = (WBEATS > 1) ? $clog2(WBEATS) : 1;
  localparam int RB_W   = (RBEATS > 1) ? $clog2(RBEATS) : 1;
  localparam int AW     = $clog2(FRAME_LEN);

  logic [DATA_W-1:0] mem_re [2][FRAME_LEN];
  logic [DATA_W-1:0] mem_im [2][FRAME_LEN];

  logic [WB_W-1:0]  wb_q, wb_d;
  logic [RB_W-1:0]  rb_q, rb_d;
  logic             drop_q, drop_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic             ovf_err_q, ovf_err_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic          wr_drop, wr_en, wr_last, rd_fire, rd_last;
  logic [AW-1:0] wr_base, rd_base;

  always_comb begin
    wb_d      = wb_q;
    rb_d      = rb_q;
    drop_d    = drop_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    ovf_err_d = ovf_err_q;
    ovf_cnt_d = ovf_cnt_q;

    // Accept/drop is decided once per frame from the registered full flag;
    // a bank freed on the same edge does not count.
    wr_drop = (wb_q == '0) ? full_q[wr_bank_q] : drop_q;
    wr_en   = valid_in && !wr_drop;
    wr_last = (wb_q == WB_W'(WBEATS - 1));
    rd_fire = out_valid && out_ready;
    rd_last = (rb_q == RB_W'(RBEATS - 1));

    if (valid_in) begin
      wb_d   = wr_last ? '0 : wb_q + 1'b1;
      drop_d = wr_drop;
      if (wr_last) begin
        if (wr_drop) begin
          ovf_err_d = 1'b1;
          if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
        end else begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
    end

    if (rd_fire) begin
      rb_d = rd_last ? '0 : rb_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q      <= '0;
      rb_q      <= '0;
      drop_q    <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      ovf_err_q <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      drop_q    <= drop_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      ovf_err_q <= ovf_err_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign wr_base = AW'(wb_q) * AW'(LANES_IN);
  assign rd_base = AW'(rb_q) * AW'(LANES_OUT);

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES_IN; k++) begin
        mem_re[wr_bank_q][wr_base + AW'(k)] <= data_re_in[k];
        mem_im[wr_bank_q][wr_base + AW'(k)] <= data_im_in[k];
      end
    end
  end

  assign out_valid    = full_q[rd_bank_q];
  assign out_sof      = out_valid && (rb_q == '0);
  assign out_eof      = out_valid && rd_last;
  assign overflow_err = ovf_err_q;
  assign overflow_cnt = ovf_cnt_q;

  for (genvar j = 0; j < LANES_OUT; j++) begin : g_out
    assign out_re[j] = out_valid ? mem_re[rd_bank_q][rd_base + AW'(j)] : '0;
    assign out_im[j] = out_valid ? mem_im[rd_bank_q][rd_base + AW'(j)] : '0;
  end

endmodule

// File: doc/cbfp_out_frame_buffer.md
Name: cbfp_out_frame_buffer

Overview:
- Receiving end of the CBFP streaming output interface.
- Accepts normalized 16-lane complex frames (512 samples, 32 beats, valid-only, no backpressure) into a two-bank ping-pong store.
- Replays each frame as a narrower ready/valid stream with start-of-frame and end-of-frame markers, toward the downstream consumer.
- Frames that arrive while both banks are occupied are dropped and counted.

Parameters:
- DATA_W, 13: bit width of each real/imag sample, equal to the CBFP OUT_W.
- LANES_IN, 16: samples per input beat.
- LANES_OUT, 4: samples per output beat; must divide FRAME_LEN.
- FRAME_LEN, 512: complex samples per frame.
- CNT_W, 8: width of the overflow counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  input beat valid; no ready is returned.
- data_re_in  in  [DATA_W-1:0] x LANES_IN (unpacked [0:15])  signed real samples.
- data_im_in  in  [DATA_W-1:0] x LANES_IN  signed imag samples.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_re  out  [DATA_W-1:0] x LANES_OUT  signed real samples.
- out_im  out  [DATA_W-1:0] x LANES_OUT  signed imag samples.
- out_sof  out  1  high with the first beat of a frame.
- out_eof  out  1  high with the last beat of a frame.
- overflow_err  out  1  sticky, set on the first dropped frame.
- overflow_cnt  out  CNT_W  number of dropped frames, saturating.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, out_sof, out_eof, overflow_err = 0; overflow_cnt = 0.
  - Both banks empty; write bank = 0, read bank = 0; write beat counter = 0, read beat counter = 0.
  - Storage contents are not reset.
- Sample order: lane k of input beat b is frame sample LANES_IN*b+k. Output lane j of output beat r is sample LANES_OUT*r+j. Data is passed unmodified.
- Write side:
  - The beat counter wb (0..31) advances only on valid_in. Gaps between beats are allowed, and cycles with valid_in=0 are ignored.
  - At wb=0 with valid_in, the frame is accepted if the write bank is empty; otherwise the whole frame is put in drop mode.
    - Drop mode: beats are counted but not stored. On the beat with wb=31, overflow_cnt increments (saturating at all-ones) and overflow_err is set.
  - The empty check uses the registered bank-full flag. A bank freed by the reader in the same cycle does not rescue that frame.
  - On an accepted beat with wb=31, the bank is marked full at that edge and the write bank toggles. wb then wraps to 0.
- Read side:
  - out_valid = read bank full (registered flag). First out_valid is the cycle after the clock edge that captured the last input beat: 1-cycle latency.
  - out_re/out_im are driven from read bank entries LANES_OUT*rb .. LANES_OUT*rb+LANES_OUT-1. They are 0 when out_valid=0.
  - out_sof = out_valid && rb==0. out_eof = out_valid && rb==FRAME_LEN/LANES_OUT-1.
  - rb advances on out_valid && out_ready. With out_valid=1 and out_ready=0, all outputs are held stable.
  - On an accepted beat with rb = last: the bank is marked empty, the read bank toggles, and rb wraps to 0.
    - If the other bank is already full, out_valid stays high and the next frame's first beat (sof) appears the next cycle with no bubble.
- Simultaneous events: the write-complete and read-free actions on different banks in the same cycle both take effect. Writer and reader never target the same bank while it is full.
- Reset mid-operation: a partial input frame and partial output frame are discarded. The next valid_in beat is treated as wb=0.
- Throughput: with LANES_OUT=4, the output needs 128 beats per frame against 32 input beats. Sustained back-to-back input therefore drops frames by design.

Test Plan:
- Single frame, out_ready=1. Input pattern re=idx+100, im=idx+200, idx=0..511 over 32 beats. Required: out_valid one cycle after the last input beat. Beat 0: sof=1, re=100,101,102,103, im=200..203. 128 beats total. Beat 127: eof=1, re=608..611. Then out_valid=0.
- Backpressure: same frame with out_ready alternating 1,0. Required: outputs stable while stalled, 128 beats in order, identical values to the previous case, overflow_cnt=0.
- Gapped input: valid_in asserted every third cycle for the same frame. Required: output identical to the single-frame case.
- Overflow: three frames back-to-back (input cycles 0-95), out_ready=1. Required:
  - Frame 0 output in cycles 32-159.
  - Frame 1 output in cycles 160-287, with sof immediately after frame 0's eof (no bubble).
  - Frame 2 dropped: overflow_cnt=1, overflow_err=1 after its 32nd beat.
- Coincident free: frame 0 drained so that its final output accept occurs in the same cycle as a new frame's wb=0 beat, with the other bank full. Required: the new frame is dropped and overflow_cnt increments.
- Reset mid-frame: rst_n pulsed low after 10 input beats. Required: outputs 0 immediately (async). A following full frame with idx pattern +1000 emits beat 0 re=1000..1003 with sof=1, and no residue from the aborted frame.
